// File: rtl/countdown_timer_core.sv
// countdown_timer_core: MM:SS BCD countdown / count-up timer engine with debounced buttons,
// saturating preset editing, pause and a blinking finish indication.
module countdown_timer_core #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LED_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_inc,
    input  logic             i_btn_dec,
    input  logic             i_btn_start,
    input  logic             i_btn_clr,
    input  logic [1:0]       i_digit_sel,
    input  logic             i_mode_up,
    output logic [1:0]       o_state,
    output logic [3:0]       o_cur_m1,
    output logic [3:0]       o_cur_m0,
    output logic [3:0]       o_cur_s1,
    output logic [3:0]       o_cur_s0,
    output logic [3:0]       o_pre_m1,
    output logic [3:0]       o_pre_m0,
    output logic [3:0]       o_pre_s1,
    output logic [3:0]       o_pre_s0,
    output logic             o_tick,
    output logic             o_done,
    output logic [LED_W-1:0] o_led
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [PW-1:0] SEC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF_LAST = PW'(CLK_HZ / 2 - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {SET, RUN, PAUSE, DONE} state_t;

    state_t        r_state, w_next;
    logic [3:0]    w_btn, r_s1, r_s2, r_db, w_p;
    logic [DW-1:0] r_dcnt [4];
    logic [15:0]   r_pre, r_cur, w_cur;
    logic [PW-1:0] r_psc;
    logic          r_up, r_phase, w_fin, w_tick;
    logic          w_inc, w_dec, w_start, w_clr;

    // Add/subtract one unit at digit pos with ripple carry/borrow; overflow saturates at 99:59 / 00:00.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic [1:0] pos, input logic up);
        logic [15:0] r;
        logic [3:0]  lim;
        logic        c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lim = (k == 1) ? 4'd5 : 4'd9;
            if (k >= int'(pos) && c) begin
                if (r[4*k +: 4] == (up ? lim : 4'd0))
                    r[4*k +: 4] = up ? 4'd0 : lim;
                else begin
                    r[4*k +: 4] = up ? r[4*k +: 4] + 4'd1 : r[4*k +: 4] - 4'd1;
                    c = 1'b0;
                end
            end
        end
        return c ? (up ? 16'h9959 : 16'h0000) : r;
    endfunction

    assign w_btn = {i_btn_clr, i_btn_start, i_btn_dec, i_btn_inc};

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_db <= '0;
            for (int k = 0; k < 4; k++) r_dcnt[k] <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
            for (int k = 0; k < 4; k++)
                if (r_s2[k] == r_db[k]) r_dcnt[k] <= '0;
                else if (r_dcnt[k] == DB_LAST) begin
                    r_dcnt[k] <= '0;
                    r_db[k]   <= r_s2[k];
                end else r_dcnt[k] <= r_dcnt[k] + 1'b1;
        end

    always_comb begin
        w_p = '0;
        for (int k = 0; k < 4; k++) w_p[k] = r_s2[k] & ~r_db[k] & (r_dcnt[k] == DB_LAST);
    end

    assign {w_clr, w_start, w_dec, w_inc} = w_p;
    assign w_fin  = r_up ? (r_cur == r_pre) : (r_cur == 16'h0000);
    assign w_tick = (r_state == RUN) && (r_psc == SEC_LAST) && !w_clr && !w_fin;
    assign w_cur  = (r_state == SET) ? (i_mode_up ? 16'h0000 : r_pre) : r_cur;

    always_comb begin
        w_next = r_state;
        if (w_clr) w_next = SET;
        else
            case (r_state)
                SET:     if (w_start) w_next = RUN;
                RUN:     if (w_fin) w_next = DONE; else if (w_start) w_next = PAUSE;
                PAUSE:   if (w_start) w_next = RUN;
                default: w_next = DONE;
            endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= SET;
        else r_state <= w_next;

    // The prescaler doubles as the half-second blink counter once DONE is reached.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_pre   <= '0;
            r_cur   <= '0;
            r_psc   <= '0;
            r_up    <= 1'b0;
            r_phase <= 1'b0;
        end else if (w_clr) begin
            r_psc   <= '0;
            r_phase <= 1'b0;
        end else
            case (r_state)
                SET:
                    if (w_start) begin
                        r_up  <= i_mode_up;
                        r_cur <= w_cur;
                        r_psc <= '0;
                    end else if (w_inc ^ w_dec) r_pre <= bcd_step(r_pre, i_digit_sel, w_inc);
                RUN:
                    if (w_fin) begin
                        r_psc   <= '0;
                        r_phase <= 1'b1;
                    end else if (w_tick) begin
                        r_psc <= '0;
                        r_cur <= bcd_step(r_cur, 2'd0, r_up);
                    end else r_psc <= r_psc + 1'b1;
                DONE:
                    if (r_psc == HALF_LAST) begin
                        r_psc   <= '0;
                        r_phase <= ~r_phase;
                    end else r_psc <= r_psc + 1'b1;
                default: ;
            endcase

    assign o_state = r_state;
    assign {o_cur_m1, o_cur_m0, o_cur_s1, o_cur_s0} = w_cur;
    assign {o_pre_m1, o_pre_m0, o_pre_s1, o_pre_s0} = r_pre;
    assign o_tick  = w_tick;
    assign o_done  = (r_state == DONE);
    assign o_led   = {LED_W{r_phase}};
endmodule

// File: tb/tb_countdown_timer_core.sv
// tb_countdown_timer_core: table-driven preset editing, randomized edits and runs checked
// against a seconds-based reference model, plus run/pause/blink/clear/reset sequences.
module tb_countdown_timer_core;
    logic        clk = 1'b0, rst_n = 1'b0, mode_up = 1'b0;
    logic [3:0]  btn = '0;
    logic [1:0]  sel = '0;
    logic [1:0]  state;
    logic [3:0]  cm1, cm0, cs1, cs0, pm1, pm0, ps1, ps0;
    logic        tick, done;
    logic [7:0]  led;
    logic [15:0] cur, pre;
    int          n_chk = 0, n_fail = 0, n_run = 0, n_tick = 0;

    assign cur = {cm1, cm0, cs1, cs0};
    assign pre = {pm1, pm0, ps1, ps0};

    always #5 clk = ~clk;

    countdown_timer_core #(.CLK_HZ(10), .DEBOUNCE_CYC(2), .LED_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_inc(btn[0]), .i_btn_dec(btn[1]), .i_btn_start(btn[2]), .i_btn_clr(btn[3]),
        .i_digit_sel(sel), .i_mode_up(mode_up), .o_state(state),
        .o_cur_m1(cm1), .o_cur_m0(cm0), .o_cur_s1(cs1), .o_cur_s0(cs0),
        .o_pre_m1(pm1), .o_pre_m0(pm0), .o_pre_s1(ps1), .o_pre_s0(ps0),
        .o_tick(tick), .o_done(done), .o_led(led)
    );

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  sel;
        int          n;
        int          hold;
        logic        md;
        logic [15:0] pre;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [15:0] to_bcd(input int v);
        int m, s;
        m = v / 60;
        s = v % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int weight(input logic [1:0] d);
        return d == 2'd0 ? 1 : d == 2'd1 ? 10 : d == 2'd2 ? 60 : 600;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (state == 2'd1) n_run++;
        if (tick) n_tick++;
    endtask

    task automatic press(input logic [3:0] m, input int hold = 6);
        btn = m;
        repeat (hold) step();
        btn = '0;
        repeat (6) step();
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (state !== s && k < 20);
        chk(name, state, s);
    endtask

    task automatic set_preset(input int v);
        logic [15:0] b;
        b = to_bcd(v);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 4; d++) begin
            sel = 2'(d);
            for (int k = 0; k < int'(b[4*d +: 4]); k++) press(4'b0001);
        end
        chk("set_preset", pre, b);
    endtask

    // Model: one second elapses every 10 RUN cycles; value moves by 1 s until the target.
    task automatic do_run(input int pre_s, input bit up, input bit pz, input bit flip);
        int v, t0;
        logic [15:0] held;
        bit ok;
        mode_up = up;
        step();
        chk("set_cur", cur, up ? 16'h0 : to_bcd(pre_s));
        v  = up ? 0 : pre_s;
        t0 = n_tick;
        n_run = 0;
        btn = 4'b0100;
        wait_state(2'd1, "enter_run");
        btn = '0;
        if (flip) mode_up = !up;
        for (int i = 1; i <= pre_s; i++) begin
            int k;
            k = 0;
            do begin
                step();
                k++;
            end while (!tick && k < 40);
            chk("tick_seen", tick, 1);
            chk("tick_phase", n_run, 10 * i);
            chk("cur_at_tick", cur, to_bcd(v));
            v = up ? v + 1 : v - 1;
            if (pz && i == 1) begin
                btn = 4'b0100;
                wait_state(2'd2, "enter_pause");
                btn  = '0;
                held = cur;
                ok   = 1'b1;
                repeat (100) begin
                    step();
                    if (state !== 2'd2 || cur !== held || tick) ok = 1'b0;
                end
                chk("pause_hold", ok, 1);
                chk("pause_cur", held, to_bcd(v));
                btn = 4'b0100;
                wait_state(2'd1, "resume");
                btn = '0;
            end
        end
        if (pre_s > 0) step();
        chk("terminal_cur", cur, to_bcd(v));
        chk("terminal_state", state, 2'd1);
        step();
        chk("done_state", state, 2'd3);
        chk("done_flag", done, 1);
        chk("done_led", led, 8'hFF);
        chk("tick_count", n_tick - t0, pre_s);
        mode_up = up;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int mp;
        tbl[0]  = '{4'b0001, 2'd2,  3,  6, 1'b0, 16'h0300};
        tbl[1]  = '{4'b0001, 2'd0,  5,  6, 1'b0, 16'h0305};
        tbl[2]  = '{4'b0011, 2'd0,  2,  6, 1'b1, 16'h0305};
        tbl[3]  = '{4'b0001, 2'd0,  1, 50, 1'b0, 16'h0306};
        tbl[4]  = '{4'b0001, 2'd0,  1,  1, 1'b0, 16'h0306};
        tbl[5]  = '{4'b0010, 2'd3,  1,  6, 1'b0, 16'h0000};
        tbl[6]  = '{4'b0001, 2'd3,  9,  6, 1'b0, 16'h9000};
        tbl[7]  = '{4'b0001, 2'd2,  9,  6, 1'b1, 16'h9900};
        tbl[8]  = '{4'b0001, 2'd1,  5,  6, 1'b0, 16'h9950};
        tbl[9]  = '{4'b0001, 2'd1,  1,  6, 1'b0, 16'h9959};
        tbl[10] = '{4'b0001, 2'd0,  1,  6, 1'b0, 16'h9959};
        tbl[11] = '{4'b0010, 2'd0,  1,  6, 1'b0, 16'h9958};
        tbl[12] = '{4'b0010, 2'd1,  1,  6, 1'b0, 16'h9948};
        tbl[13] = '{4'b0010, 2'd2,  1,  6, 1'b0, 16'h9848};
        tbl[14] = '{4'b0010, 2'd3, 10,  6, 1'b0, 16'h0000};
        tbl[15] = '{4'b0001, 2'd0,  5,  6, 1'b0, 16'h0005};
        tbl[16] = '{4'b0010, 2'd3,  1,  6, 1'b0, 16'h0000};
        tbl[17] = '{4'b0001, 2'd0, 10,  6, 1'b1, 16'h0010};
        tbl[18] = '{4'b0010, 2'd0,  1,  6, 1'b0, 16'h0009};
        tbl[19] = '{4'b1000, 2'd0,  1,  6, 1'b0, 16'h0009};

        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_cur", cur, 16'h0);
        chk("rst_pre", pre, 16'h0);
        chk("rst_led", led, 8'h0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        step();
        rst_n = 1'b1;
        step();

        for (int r = 0; r < 20; r++) begin
            mode_up = tbl[r].md;
            sel     = tbl[r].sel;
            repeat (tbl[r].n) press(tbl[r].mask, tbl[r].hold);
            chk($sformatf("vec%0d_pre", r), pre, tbl[r].pre);
            chk($sformatf("vec%0d_cur", r), cur, tbl[r].md ? 16'h0 : tbl[r].pre);
        end

        mp = 9;
        for (int r = 0; r < 24; r++) begin
            int op;
            op      = int'($urandom_range(0, 3));
            sel     = 2'($urandom_range(0, 3));
            mode_up = 1'($urandom_range(0, 1));
            if (op == 0) begin
                press(4'b0001);
                mp = (mp + weight(sel) > 5999) ? 5999 : mp + weight(sel);
            end else if (op == 1) begin
                press(4'b0010);
                mp = (mp - weight(sel) < 0) ? 0 : mp - weight(sel);
            end else press(op == 2 ? 4'b0011 : 4'b1000);
            chk("rnd_pre", pre, to_bcd(mp));
            chk("rnd_cur", cur, mode_up ? 16'h0 : to_bcd(mp));
        end

        set_preset(3);
        do_run(3, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            step();
            chk("blink", led, ((k / 5) % 2 == 0) ? 8'hFF : 8'h00);
        end
        press(4'b0111);
        chk("done_ignores_btns", state, 2'd3);
        press(4'b1000);
        chk("clr_state", state, 2'd0);
        chk("clr_led", led, 8'h0);
        chk("clr_cur", cur, 16'h0003);
        chk("clr_done", done, 0);

        set_preset(2);
        do_run(2, 1'b1, 1'b0, 1'b1);
        press(4'b1000);
        chk("up_clr_cur", cur, 16'h0);

        set_preset(10);
        do_run(10, 1'b0, 1'b1, 1'b0);
        press(4'b1000);

        set_preset(0);
        do_run(0, 1'b0, 1'b0, 1'b0);
        press(4'b1000);
        do_run(0, 1'b1, 1'b0, 1'b0);
        press(4'b1000);

        for (int r = 0; r < 3; r++) begin
            int p;
            bit u, z;
            p = int'($urandom_range(0, 4));
            u = 1'($urandom_range(0, 1));
            z = (p >= 2) && 1'($urandom_range(0, 1));
            set_preset(p);
            do_run(p, u, z, 1'b0);
            press(4'b1000);
            chk("rnd_run_clr", state, 2'd0);
        end

        set_preset(5);
        mode_up = 1'b0;
        btn = 4'b0100;
        wait_state(2'd1, "rst_run_enter");
        btn = '0;
        repeat (13) step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", state, 2'd0);
        chk("async_cur", cur, 16'h0);
        chk("async_pre", pre, 16'h0);
        chk("async_led", led, 8'h0);
        chk("async_tick", tick, 0);
        chk("async_done", done, 0);
        step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("no_resume_state", state, 2'd0);
        chk("no_resume_cur", cur, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
